// File: rtl/rv_pkg.sv
// Shared RISC-V decode constants: immediate format codes, major opcodes and
// the funct3 values needed to split shift and SYSTEM/CSR encodings.
package rv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6,
    FMT_N = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SRX    = 3'b101;
  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

endpackage

// File: rtl/rv_imm_decode.sv
// Combinational immediate generator: instruction word to XLEN-wide immediate,
// format code and illegal-opcode flag.
module rv_imm_decode
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic        is_shift;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign is_shift = (f3 == F3_SLL) || (f3 == F3_SRX);

  // Every format is first assembled as a 32-bit signed value, then widened.
  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  always_comb begin
    imm     = '0;
    fmt     = FMT_N;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        imm = sx(i_imm);
      end
      OPC_OPIMM: begin
        fmt = FMT_I;
        if (is_shift)
          imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
        else
          imm = sx(i_imm);
      end
      OPC_OPIMM32: begin
        if (XLEN == 64) begin
          fmt = FMT_I;
          imm = is_shift ? XLEN'(instr[24:20]) : sx(i_imm);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = sx(s_imm);
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = sx(b_imm);
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = sx(u_imm);
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = sx(j_imm);
      end
      OPC_SYSTEM: begin
        case (f3)
          F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: begin
            fmt = FMT_Z;
            imm = XLEN'(instr[19:15]);
          end
          F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
            fmt = FMT_I;
            imm = XLEN'(instr[31:20]);
          end
          default: fmt = FMT_N;
        endcase
      end
      OPC_OP: fmt = FMT_R;
      OPC_OP32: begin
        if (XLEN == 64) fmt = FMT_R;
        else            illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_imm_decode_pipe.sv
// Registered immediate-decode stage: decode on input, then a main output
// register backed by one skid entry so back-pressure never costs throughput.
module rv_imm_decode_pipe
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  d_imm;
  fmt_e             d_fmt;
  logic             d_ill;

  rv_imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm     (d_imm),
    .fmt     (d_fmt),
    .illegal (d_ill)
  );

  logic             main_v, skid_v;
  logic [XLEN-1:0]  main_imm, skid_imm;
  fmt_e             main_fmt, skid_fmt;
  logic             main_ill, skid_ill;
  logic [31:0]      main_instr, skid_instr;
  logic [TAG_W-1:0] main_tag, skid_tag;
  logic             accept;

  // skid_v is itself a flop, so in_ready never sees out_ready combinationally.
  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      main_imm   <= '0;
      main_fmt   <= FMT_R;
      main_ill   <= 1'b0;
      main_instr <= '0;
      main_tag   <= '0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_R;
      skid_ill   <= 1'b0;
      skid_instr <= '0;
      skid_tag   <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      // Main is empty or draining: refill from skid first to keep order.
      if (skid_v) begin
        main_v     <= 1'b1;
        skid_v     <= 1'b0;
        main_imm   <= skid_imm;
        main_fmt   <= skid_fmt;
        main_ill   <= skid_ill;
        main_instr <= skid_instr;
        main_tag   <= skid_tag;
      end else begin
        main_v <= accept;
        if (accept) begin
          main_imm   <= d_imm;
          main_fmt   <= d_fmt;
          main_ill   <= d_ill;
          main_instr <= in_instr;
          main_tag   <= in_tag;
        end
      end
    end else if (accept) begin
      skid_v     <= 1'b1;
      skid_imm   <= d_imm;
      skid_fmt   <= d_fmt;
      skid_ill   <= d_ill;
      skid_instr <= in_instr;
      skid_tag   <= in_tag;
    end
  end

  assign out_valid   = main_v;
  assign out_imm     = main_imm;
  assign out_fmt     = main_fmt;
  assign out_illegal = main_ill;
  assign out_instr   = main_instr;
  assign out_tag     = main_tag;

endmodule

// File: tb/tb_rv_imm_decode_pipe.sv
// Directed bench for rv_imm_decode_pipe: one XLEN=32 and one XLEN=64 instance.
module tb_rv_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_instr, a_out_imm, a_out_instr;
  logic [3:0]  a_in_tag, a_out_tag;
  logic [2:0]  a_out_fmt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr, b_out_instr;
  logic [63:0] b_out_imm;
  logic [3:0]  b_in_tag, b_out_tag;
  logic [2:0]  b_out_fmt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_imm_decode_pipe #(.XLEN(32), .TAG_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_illegal(a_out_illegal), .out_instr(a_out_instr), .out_tag(a_out_tag)
  );

  rv_imm_decode_pipe #(.XLEN(64), .TAG_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
    .out_illegal(b_out_illegal), .out_instr(b_out_instr), .out_tag(b_out_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_drive(input logic v, input logic [31:0] ins, input logic [3:0] t);
    a_in_valid = v;
    a_in_instr = ins;
    a_in_tag   = t;
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_instr = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_instr = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_a_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_ready", 64'(a_in_ready), 64'd1);
    chk("rst_a_imm", 64'(a_out_imm), 64'd0);
    chk("rst_a_fmt_ill", 64'({a_out_fmt, a_out_illegal}), 64'd0);
    chk("rst_a_instr_tag", 64'({a_out_instr, a_out_tag}), 64'd0);
    chk("rst_b_state", 64'({b_out_valid, b_in_ready, b_out_fmt, b_out_illegal, b_out_tag}), 64'b01_000_0_0000);
    chk("rst_b_imm_instr", b_out_imm | 64'(b_out_instr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // addi x1,x0,-1
    a_drive(1'b1, 32'hFFF00093, 4'd5);
    @(negedge clk);
    chk("addi_valid", 64'(a_out_valid), 64'd1);
    chk("addi_imm", 64'(a_out_imm), 64'hFFFF_FFFF);
    chk("addi_fmt_ill", 64'({a_out_fmt, a_out_illegal}), {60'd0, 3'd1, 1'b0});
    chk("addi_tag_instr", 64'({a_out_instr, a_out_tag}), {28'd0, 32'hFFF00093, 4'd5});

    // Back-to-back branch then srai
    a_drive(1'b1, 32'h80000063, 4'd6);
    @(negedge clk);
    chk("beq_imm", 64'(a_out_imm), 64'hFFFF_F000);
    chk("beq_fmt", 64'(a_out_fmt), 64'd3);
    chk("beq_ready", 64'(a_in_ready), 64'd1);
    a_drive(1'b1, 32'h40105093, 4'd7);
    @(negedge clk);
    chk("srai_imm", 64'(a_out_imm), 64'd1);
    chk("srai_fmt", 64'(a_out_fmt), 64'd1);
    chk("srai_ready_tag", 64'({a_in_ready, a_out_tag}), {59'd0, 1'b1, 4'd7});

    // csrrwi zimm=31, then an unknown opcode, then slli shamt 63 (truncated to 31 on RV32)
    a_drive(1'b1, 32'h340FD073, 4'd8);
    @(negedge clk);
    chk("csrrwi_imm", 64'(a_out_imm), 64'h1F);
    chk("csrrwi_fmt", 64'(a_out_fmt), 64'd6);
    a_drive(1'b1, 32'h0000007F, 4'd9);
    @(negedge clk);
    chk("illop_imm", 64'(a_out_imm), 64'd0);
    chk("illop_fmt_ill", 64'({a_out_fmt, a_out_illegal}), {60'd0, 3'd7, 1'b1});
    a_drive(1'b1, 32'h03F01013, 4'd10);
    @(negedge clk);
    chk("slli32_imm", 64'(a_out_imm), 64'd31);
    a_drive(1'b1, 32'h0000001B, 4'd11);
    @(negedge clk);
    chk("opimm32_rv32_ill", 64'({a_out_fmt, a_out_illegal}), {60'd0, 3'd7, 1'b1});
    a_drive(1'b1, 32'h00208033, 4'd12);
    @(negedge clk);
    chk("add_fmt_ill", 64'({a_out_fmt, a_out_illegal, a_out_imm}), {28'd0, 3'd0, 1'b0, 32'd0});
    a_drive(1'b0, 32'h0, 4'd0);
    @(negedge clk);
    chk("drain_empty", 64'(a_out_valid), 64'd0);

    // RV64 instance: lui sign-extension, shamt 6 bits, OP-IMM-32 shift
    b_in_valid = 1'b1; b_in_instr = 32'h800000B7; b_in_tag = 4'd1;
    @(negedge clk);
    chk("lui64_imm", b_out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui64_fmt", 64'({b_out_valid, b_out_fmt, b_out_illegal}), {59'd0, 1'b1, 3'd4, 1'b0});
    b_in_instr = 32'h03F01013; b_in_tag = 4'd2;
    @(negedge clk);
    chk("slli64_imm", b_out_imm, 64'd63);
    b_in_instr = 32'h03F0101B; b_in_tag = 4'd3;
    @(negedge clk);
    chk("slliw64_imm", b_out_imm, 64'd31);
    chk("slliw64_fmt", 64'({b_out_fmt, b_out_illegal, b_out_tag, b_out_instr}), {24'd0, 3'd1, 1'b0, 4'd3, 32'h03F0101B});
    b_in_instr = 32'hFFF00003; b_in_tag = 4'd4;
    @(negedge clk);
    chk("lb64_imm", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_drain", 64'({b_out_valid, b_in_ready}), 64'b01);

    // Back-pressure: tags 1,2 accepted, 3 held off, then in-order release
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'h00000013, 4'd1);
    @(negedge clk);
    chk("bp_t1_out", 64'({a_out_valid, a_out_tag, a_in_ready}), {58'd0, 1'b1, 4'd1, 1'b1});
    a_drive(1'b1, 32'h00000013, 4'd2);
    @(negedge clk);
    chk("bp_ready_fall", 64'({a_in_ready, a_out_tag}), {59'd0, 1'b0, 4'd1});
    a_drive(1'b1, 32'h00000013, 4'd3);
    @(negedge clk);
    chk("bp_hold", 64'({a_in_ready, a_out_valid, a_out_tag}), {58'd0, 1'b0, 1'b1, 4'd1});
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_t2", 64'({a_out_valid, a_out_tag, a_in_ready}), {58'd0, 1'b1, 4'd2, 1'b1});
    @(negedge clk);
    chk("bp_rel_t3", 64'({a_out_valid, a_out_tag}), {59'd0, 1'b1, 4'd3});
    a_drive(1'b0, 32'h0, 4'd0);
    @(negedge clk);
    chk("bp_no_dup", 64'(a_out_valid), 64'd0);

    // Flush with both entries full and an offer pending
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'h00000013, 4'd4);
    @(negedge clk);
    a_drive(1'b1, 32'h00000013, 4'd5);
    @(negedge clk);
    chk("fl_full", 64'({a_in_ready, a_out_valid}), 64'b01);
    a_drive(1'b1, 32'h00000013, 4'd6);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    chk("fl_cleared", 64'({a_out_valid, a_in_ready}), 64'b01);
    a_drive(1'b0, 32'h0, 4'd0);
    a_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("fl_gone", 64'(a_out_valid), 64'd0);

    // Flush dominates a same-cycle accept
    a_drive(1'b1, 32'h00000013, 4'd9);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    a_drive(1'b0, 32'h0, 4'd0);
    chk("fl_accept_drop", 64'({a_out_valid, a_in_ready}), 64'b01);

    // Asynchronous reset mid-stall
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'hFFF00093, 4'd7);
    @(negedge clk);
    a_drive(1'b1, 32'hFFF00093, 4'd8);
    @(negedge clk);
    a_drive(1'b1, 32'hFFF00093, 4'd9);
    chk("rs_stalled", 64'({a_in_ready, a_out_valid, a_out_tag}), {58'd0, 1'b0, 1'b1, 4'd7});
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_vr", 64'({a_out_valid, a_in_ready}), 64'b01);
    chk("rs_async_data", 64'({a_out_imm, a_out_fmt, a_out_illegal, a_out_tag}), 64'd0);
    chk("rs_async_instr", 64'(a_out_instr), 64'd0);
    a_drive(1'b0, 32'h0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_after", 64'({a_out_valid, a_in_ready}), 64'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
